bicubic_weight_sched: RTL and testbench
=======================================

BICUBIC_WEIGHT_SCHED -- requirements
Module: bicubic_weight_sched

Interface
REQ-001 Parameter KRN_LAT, default 6: cycles from krn_valid issue to matching krn_res_valid at the shared weight kernel; legal range 1..15.
REQ-002 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-003 Ports: rst  in  1  asynchronous, active-high reset.
REQ-004 Ports: in_valid  in  1  job request; in_ready  out  1  job accepted when both high.
REQ-005 Ports: in_frac  in  8  fractional offset f, Q0.8; in_a  in  9  kernel coefficient a.
REQ-006 Ports: krn_valid  out  1  tap issue strobe; krn_base  out  9  integer part of tap distance, Q1.8; krn_blend  out  9  fractional part of tap distance, Q1.8.
REQ-007 Ports: krn_a  out  9  coefficient to kernel; krn_half  out  9  rounding constant.
REQ-008 Ports: krn_res_valid  in  1  kernel result strobe; krn_res  in  17  kernel weight result.
REQ-009 Ports: out_valid  out  1; out_ready  in  1; out_w0..out_w3  out  17 each  tap weights.

Function
REQ-010 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-011 IDLE: in_ready=1; on in_valid&in_ready latch f=in_frac and a=in_a, clear tap and result counters, go to ISSUE.
REQ-012 ISSUE: krn_valid=1 on exactly 4 consecutive cycles, tap index t=0,1,2,3; then go to WAIT.
REQ-013 Tap distances (base, blend): t0=(256, f); t1=(0, f); t2=(0, 256-f); t3=(256, 256-f); each result is 9 bits, with no overflow for f in 0..255.
REQ-014 krn_a holds the latched a and krn_half is constant 9'd128 during ISSUE and WAIT; when krn_valid=0, krn_base and krn_blend are 0.
REQ-015 Result capture: the Nth krn_res_valid pulse after job start (N=0..3) loads out_wN from krn_res; pulses outside ISSUE/WAIT are ignored.
REQ-016 A tag shift register of depth KRN_LAT tracks issued taps; a krn_res_valid with no tag at the shift-register head sets sticky flag err_seq (internal) and still loads the next slot.
REQ-017 WAIT to DONE when the 4th result is captured, or when the tag shift register is empty, whichever is later.
REQ-018 DONE: out_valid=1 with out_w0..3 stable until out_valid&out_ready; then go to IDLE; in_ready=1 on the same cycle as the handshake is forbidden, so the minimum job period is 4+KRN_LAT+2 cycles.
REQ-019 in_ready=0 in ISSUE, WAIT and DONE; changes to in_frac or in_a after acceptance have no effect.
REQ-020 out_w0..3 hold their last value outside DONE and are not cleared between jobs.

Reset
REQ-021 Asserting rst forces IDLE immediately, regardless of the current state or any pending results.
REQ-022 Reset values: in_ready=0 while rst is high and 1 after release; krn_valid=0; out_valid=0; krn_base, krn_blend, krn_a and out_w0..3 are 0; krn_half=128; tag shift register and counters are cleared.
REQ-023 Results from the kernel that arrive after reset (from taps issued before reset) are ignored.

Configuration
REQ-024 Macro BICUBIC_SCHED_STATS_EN: when defined, add output port job_cnt [15:0], which increments on each out_valid&out_ready handshake, saturates at 16'hFFFF, and resets to 0.
REQ-025 When BICUBIC_SCHED_STATS_EN is undefined, the job_cnt port and its logic are absent and all other behaviour is identical.

Verification
REQ-026 f=0x40, a=0x1C0, KRN_LAT=6 -> krn_valid on 4 consecutive cycles with (base, blend) = (256,64), (0,64), (0,192), (256,192); krn_a=0x1C0 on each issue cycle.
REQ-027 Kernel model returns 100, 200, 300, 400 -> out_valid rises 4+6+1 cycles after acceptance; out_w0..3 = 100, 200, 300, 400.
REQ-028 Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, weights stable, in_ready=0; then out_ready=1 -> IDLE on the next cycle.
REQ-029 Boundary values: f=0 -> t2/t3 blend=256; f=255 -> t2/t3 blend=1; no truncation of either.
REQ-030 Assert rst during WAIT after 2 results -> out_valid=0 immediately; late results ignored; the next job with f=0x80 completes with correct results.
REQ-031 With BICUBIC_SCHED_STATS_EN defined: 3 back-to-back jobs -> job_cnt=3; after reset, job_cnt=0.

Source files
------------

// File: rtl/bicubic_weight_sched.sv
// rtl/bicubic_weight_sched.sv - bicubic tap weight scheduler for a shared weight kernel
//
// Purpose: accepts one job (fractional offset f, coefficient a), issues the four
// bicubic tap distances to a shared pipelined weight kernel and collects the four
// returned weights. The weights are then presented on an out_valid/out_ready handshake.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         job handshake; in_frac (Q0.8 f), in_a (coefficient)
//   krn_valid                 tap issue strobe to the kernel
//   krn_base/krn_blend        integer / fractional tap distance, Q1.8
//   krn_a/krn_half            coefficient and rounding constant to the kernel
//   krn_res_valid/krn_res     kernel result strobe and weight
//   out_valid/out_ready       result handshake; out_w0..out_w3 tap weights
//   job_cnt                   completed-job counter (only with BICUBIC_SCHED_STATS_EN)
//
// Optional feature macro: BICUBIC_SCHED_STATS_EN adds the saturating job_cnt output.

module bicubic_weight_sched #(
  parameter int KRN_LAT = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_frac,
  input  logic [8:0]  in_a,
  output logic        krn_valid,
  output logic [8:0]  krn_base,
  output logic [8:0]  krn_blend,
  output logic [8:0]  krn_a,
  output logic [8:0]  krn_half,
  input  logic        krn_res_valid,
  input  logic [16:0] krn_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] out_w0,
  output logic [16:0] out_w1,
  output logic [16:0] out_w2,
  output logic [16:0] out_w3
`ifdef BICUBIC_SCHED_STATS_EN
  ,
  output logic [15:0] job_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         f_q, f_d;
  logic [8:0]         a_q, a_d;
  logic [1:0]         tap_q, tap_d;
  logic [2:0]         res_cnt_q, res_cnt_d;
  logic [KRN_LAT-1:0] tag_q, tag_d;
  logic [16:0]        w0_q, w0_d, w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  logic               err_seq_q, err_seq_d;
  logic               active;
  logic               capture;
  logic [8:0]         blend_f, blend_nf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      f_q       <= '0;
      a_q       <= '0;
      tap_q     <= '0;
      res_cnt_q <= '0;
      tag_q     <= '0;
      w0_q      <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
      w3_q      <= '0;
      err_seq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      f_q       <= f_d;
      a_q       <= a_d;
      tap_q     <= tap_d;
      res_cnt_q <= res_cnt_d;
      tag_q     <= tag_d;
      w0_q      <= w0_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      w3_q      <= w3_d;
      err_seq_q <= err_seq_d;
    end
  end

  // Distances for taps t0..t3: (1+f), f, (1-f), (2-f) split into base/blend.
  assign blend_f  = {1'b0, f_q};
  assign blend_nf = 9'd256 - {1'b0, f_q};

  always_comb begin
    state_d   = state_q;
    f_d       = f_q;
    a_d       = a_q;
    tap_d     = tap_q;
    res_cnt_d = res_cnt_q;
    w0_d      = w0_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    w3_d      = w3_q;
    in_ready  = (state_q == IDLE) && !rst;
    krn_valid = (state_q == ISSUE);
    out_valid = (state_q == DONE);
    krn_base  = '0;
    krn_blend = '0;

    if (krn_valid) begin
      case (tap_q)
        2'd0:    begin krn_base = 9'd256; krn_blend = blend_f;  end
        2'd1:    begin krn_base = 9'd0;   krn_blend = blend_f;  end
        2'd2:    begin krn_base = 9'd0;   krn_blend = blend_nf; end
        default: begin krn_base = 9'd256; krn_blend = blend_nf; end
      endcase
    end

    // Tags enter at bit 0 on issue; the head bit lines up with the result KRN_LAT cycles later.
    tag_d = (tag_q << 1) | KRN_LAT'(krn_valid);

    // Kernel results only count while a job is in flight; extra pulses past the
    // fourth are dropped rather than wrapping onto slot 0.
    active    = (state_q == ISSUE) || (state_q == WAIT);
    capture   = active && krn_res_valid && (res_cnt_q < 3'd4);
    err_seq_d = err_seq_q | (active && krn_res_valid && !tag_q[KRN_LAT-1]);

    if (capture) begin
      res_cnt_d = res_cnt_q + 3'd1;
      case (res_cnt_q[1:0])
        2'd0:    w0_d = krn_res;
        2'd1:    w1_d = krn_res;
        2'd2:    w2_d = krn_res;
        default: w3_d = krn_res;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          f_d       = in_frac;
          a_d       = in_a;
          tap_d     = '0;
          res_cnt_d = '0;
          tag_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        tap_d = tap_q + 2'd1;
        if (tap_q == 2'd3) state_d = WAIT;
      end
      WAIT: begin
        // Leave only once all four weights are in and no issued tap is still outstanding.
        if ((res_cnt_d == 3'd4) && (tag_d == '0)) state_d = DONE;
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  assign krn_a    = a_q;
  assign krn_half = 9'd128;
  assign out_w0   = w0_q;
  assign out_w1   = w1_q;
  assign out_w2   = w2_q;
  assign out_w3   = w3_q;

`ifdef BICUBIC_SCHED_STATS_EN
  logic [15:0] job_cnt_q, job_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) job_cnt_q <= '0;
    else     job_cnt_q <= job_cnt_d;
  end

  always_comb begin
    job_cnt_d = job_cnt_q;
    if (out_valid && out_ready && (job_cnt_q != 16'hFFFF)) job_cnt_d = job_cnt_q + 16'd1;
  end

  assign job_cnt = job_cnt_q;
`endif

endmodule

// File: tb/tb_bicubic_weight_sched.sv
// tb/tb_bicubic_weight_sched.sv - directed self-checking bench for bicubic_weight_sched
//
// Purpose: drives directed jobs into bicubic_weight_sched against a fixed-latency
// kernel model and checks issued taps, captured weights, handshakes and reset.
// Ports: none (top-level bench). Honours BICUBIC_SCHED_STATS_EN for job_cnt.

module tb_bicubic_weight_sched;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_frac;
  logic [8:0]  in_a;
  logic        krn_valid;
  logic [8:0]  krn_base, krn_blend, krn_a, krn_half;
  logic        krn_res_valid;
  logic [16:0] krn_res;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_w0, out_w1, out_w2, out_w3;
`ifdef BICUBIC_SCHED_STATS_EN
  logic [15:0] job_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  bicubic_weight_sched #(.KRN_LAT(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_frac       (in_frac),
    .in_a          (in_a),
    .krn_valid     (krn_valid),
    .krn_base      (krn_base),
    .krn_blend     (krn_blend),
    .krn_a         (krn_a),
    .krn_half      (krn_half),
    .krn_res_valid (krn_res_valid),
    .krn_res       (krn_res),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_w0        (out_w0),
    .out_w1        (out_w1),
    .out_w2        (out_w2),
    .out_w3        (out_w3)
`ifdef BICUBIC_SCHED_STATS_EN
    ,
    .job_cnt       (job_cnt)
`endif
  );

  // Kernel model: fixed LAT-cycle pipeline that is deliberately not reset, so taps
  // issued before a reset still come back afterwards. Every issue is logged.
  logic [16:0] res_tab [4];
  logic [LAT-1:0] pv = '0;
  logic [16:0] pd [LAT];
  int          cyc = 0;
  int          log_n = 0;
  logic [8:0]  log_base [64];
  logic [8:0]  log_blend [64];
  logic [8:0]  log_a [64];
  int          log_cyc [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pv  <= {pv[LAT-2:0], krn_valid};
    for (int i = LAT - 1; i > 0; i--) pd[i] <= pd[i-1];
    pd[0] <= res_tab[log_n % 4];
    if (krn_valid) begin
      log_base[log_n]  <= krn_base;
      log_blend[log_n] <= krn_blend;
      log_a[log_n]     <= krn_a;
      log_cyc[log_n]   <= cyc;
      log_n            <= log_n + 1;
    end
  end

  assign krn_res_valid = pv[LAT-1];
  assign krn_res       = pd[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept one job and wait (bounded by max_lat) for out_valid; lat counts cycles after acceptance.
  task automatic start_job(input logic [7:0] f, input logic [8:0] a, input int max_lat, output int lat);
    @(negedge clk);
    in_frac  = f;
    in_a     = a;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_frac  = ~f;
    in_a     = ~a;
    lat = 1;
    while (!out_valid && lat < max_lat) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_taps(input string tag, input int s, input logic [8:0] a,
                            input logic [8:0] b0, input logic [8:0] b1,
                            input logic [8:0] b2, input logic [8:0] b3);
    chk({tag, " t0 base"},  32'(log_base[s]),      32'd256);
    chk({tag, " t1 base"},  32'(log_base[s+1]),    32'd0);
    chk({tag, " t2 base"},  32'(log_base[s+2]),    32'd0);
    chk({tag, " t3 base"},  32'(log_base[s+3]),    32'd256);
    chk({tag, " t0 blend"}, 32'(log_blend[s]),     32'(b0));
    chk({tag, " t1 blend"}, 32'(log_blend[s+1]),   32'(b1));
    chk({tag, " t2 blend"}, 32'(log_blend[s+2]),   32'(b2));
    chk({tag, " t3 blend"}, 32'(log_blend[s+3]),   32'(b3));
    chk({tag, " t0 a"},     32'(log_a[s]),         32'(a));
    chk({tag, " t3 a"},     32'(log_a[s+3]),       32'(a));
    chk({tag, " issue gap"}, 32'(log_cyc[s+3] - log_cyc[s]), 32'd3);
  endtask

  task automatic check_w(input string tag, input logic [16:0] e0, input logic [16:0] e1,
                         input logic [16:0] e2, input logic [16:0] e3);
    chk({tag, " w0"}, 32'(out_w0), 32'(e0));
    chk({tag, " w1"}, 32'(out_w1), 32'(e1));
    chk({tag, " w2"}, 32'(out_w2), 32'(e2));
    chk({tag, " w3"}, 32'(out_w3), 32'(e3));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after hs"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready after hs"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    int s;
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_frac   = '0;
    in_a      = '0;
    out_ready = 1'b0;
    res_tab[0] = 17'd100; res_tab[1] = 17'd200; res_tab[2] = 17'd300; res_tab[3] = 17'd400;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready",  32'(in_ready),  32'd0);
    chk("rst krn_valid", 32'(krn_valid), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst krn_half",  32'(krn_half),  32'd128);
    chk("rst krn_base",  32'(krn_base),  32'd0);
    chk("rst krn_blend", 32'(krn_blend), 32'd0);
    chk("rst krn_a",     32'(krn_a),     32'd0);
    chk("rst out_w0",    32'(out_w0),    32'd0);
    chk("rst out_w3",    32'(out_w3),    32'd0);
`ifdef BICUBIC_SCHED_STATS_EN
    chk("rst job_cnt",   32'(job_cnt),   32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);

    // Job 1: f=0x40, a=0x1C0, results 100..400, latency 4+6+1
    s = log_n;
    start_job(8'h40, 9'h1C0, 40, lat);
    chk("job1 latency", 32'(lat), 32'd11);
    check_taps("job1", s, 9'h1C0, 9'd64, 9'd64, 9'd192, 9'd192);
    check_w("job1", 17'd100, 17'd200, 17'd300, 17'd400);

    // Back-pressure in DONE for 10 cycles
    repeat (10) @(negedge clk);
    chk("hold out_valid", 32'(out_valid), 32'd1);
    chk("hold in_ready",  32'(in_ready),  32'd0);
    check_w("hold", 17'd100, 17'd200, 17'd300, 17'd400);
    handshake("job1");
    chk("job1 w0 kept in IDLE", 32'(out_w0), 32'd100);

    // Boundary f=0 and f=255
    res_tab[0] = 17'd5; res_tab[1] = 17'd6; res_tab[2] = 17'd7; res_tab[3] = 17'd8;
    s = log_n;
    start_job(8'h00, 9'h055, 40, lat);
    chk("f0 latency", 32'(lat), 32'd11);
    check_taps("f0", s, 9'h055, 9'd0, 9'd0, 9'd256, 9'd256);
    check_w("f0", 17'd5, 17'd6, 17'd7, 17'd8);
    handshake("f0");

    res_tab[0] = 17'h1FFFF; res_tab[1] = 17'd0; res_tab[2] = 17'h10000; res_tab[3] = 17'd1;
    s = log_n;
    start_job(8'hFF, 9'h1FF, 40, lat);
    chk("f255 latency", 32'(lat), 32'd11);
    check_taps("f255", s, 9'h1FF, 9'd255, 9'd255, 9'd1, 9'd1);
    check_w("f255", 17'h1FFFF, 17'd0, 17'h10000, 17'd1);
    handshake("f255");

    // Reset during WAIT after two results; the last two arrive after reset
    res_tab[0] = 17'd1000; res_tab[1] = 17'd2000; res_tab[2] = 17'd3000; res_tab[3] = 17'd4000;
    start_job(8'h10, 9'h020, 9, lat);
    chk("wait w0 before rst", 32'(out_w0), 32'd1000);
    chk("wait w1 before rst", 32'(out_w1), 32'd2000);
    rst = 1'b1;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst in_ready",  32'(in_ready),  32'd0);
    chk("mid rst out_w0",    32'(out_w0),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("late res ignored w2", 32'(out_w2), 32'd0);
    chk("late res ignored w3", 32'(out_w3), 32'd0);
    chk("idle after late res", 32'(in_ready), 32'd1);

    res_tab[0] = 17'd11; res_tab[1] = 17'd22; res_tab[2] = 17'd33; res_tab[3] = 17'd44;
    s = log_n;
    start_job(8'h80, 9'h100, 40, lat);
    chk("f80 latency", 32'(lat), 32'd11);
    check_taps("f80", s, 9'h100, 9'd128, 9'd128, 9'd128, 9'd128);
    check_w("f80", 17'd11, 17'd22, 17'd33, 17'd44);
    handshake("f80");

    // Back-to-back jobs after a fresh reset: minimum period 4+LAT+2 = 12
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef BICUBIC_SCHED_STATS_EN
    chk("b2b job_cnt start", 32'(job_cnt), 32'd0);
`endif
    s = log_n;
    in_frac   = 8'h20;
    in_a      = 9'h0AA;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (30) @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    chk("b2b issues",   32'(log_n - s), 32'd12);
    chk("b2b period 1", 32'(log_cyc[s+4] - log_cyc[s]),   32'd12);
    chk("b2b period 2", 32'(log_cyc[s+8] - log_cyc[s+4]), 32'd12);
    chk("b2b end idle", 32'(in_ready), 32'd1);
    check_w("b2b", 17'd11, 17'd22, 17'd33, 17'd44);
`ifdef BICUBIC_SCHED_STATS_EN
    chk("b2b job_cnt", 32'(job_cnt), 32'd3);
    rst = 1'b1;
    #1;
    chk("job_cnt after rst", 32'(job_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
